// File: rtl/sv_video_pkg.sv
// Shared video-path constants: frame geometry, upload FSM states and the
// screenshot header bytes used by the frame buffer reader.
package sv_video_pkg;

  localparam int SV_WIDTH_PX  = 160;
  localparam int SV_HEIGHT_PX = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } vbu_state_t;

  // Magic "SV" tag that opens an uploaded frame dump when the header is enabled.
  localparam logic [7:0] HDR_MAGIC0 = 8'h53;
  localparam logic [7:0] HDR_MAGIC1 = 8'h56;

endpackage

// File: rtl/vbuffer_upload_pix_packer.sv
// Collects 2-bit pixels MSB-first into a byte; only the three earlier pixels are
// stored, the fourth is merged combinationally as it arrives.
module pix_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] pix,
  output logic [7:0] packed_next
);

  logic [5:0] sr;

  assign packed_next = {sr, pix};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= {sr[3:0], pix};
    end
  end

endmodule

// File: rtl/vbuffer_upload.sv
// Streams the 2bpp frame buffer to the HPS upload channel, four pixels per byte.
// Define VBUF_UPLOAD_HEADER_EN to prefix the payload with a 4-byte header.
module vbuffer_upload
  import sv_video_pkg::*;
#(
  parameter int WIDTH_PX  = SV_WIDTH_PX,
  parameter int HEIGHT_PX = SV_HEIGHT_PX,
  parameter int ADDR_W    = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              upload,
  input  logic              rd,
  input  logic [24:0]       addr,
  output logic [7:0]        dout,
  output logic              wait_o,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [1:0]        mem_q
);

  localparam int          NBYTES   = WIDTH_PX * HEIGHT_PX / 4;
  localparam logic [24:0] NBYTES_A = 25'(NBYTES);

  // Handshake: a read is accepted only when upload=1, rd=1, the FSM is idle and
  // wait_o is low; wait_o then stays high until dout holds the requested byte.
  vbu_state_t  state;
  logic [2:0]  k;
  logic        issue;
  logic        q_valid;
  logic        last_byte;
  logic [24:0] pidx;
  logic        hdr_hit;
  logic [7:0]  hdr_byte;
  logic        in_range;
  logic        accept;
  logic [7:0]  packed_next;

  always_comb begin
`ifdef VBUF_UPLOAD_HEADER_EN
    hdr_hit = (addr < 25'd4);
    pidx    = addr - 25'd4;
    case (addr[1:0])
      2'd0:    hdr_byte = HDR_MAGIC0;
      2'd1:    hdr_byte = HDR_MAGIC1;
      2'd2:    hdr_byte = 8'(WIDTH_PX);
      default: hdr_byte = 8'(HEIGHT_PX);
    endcase
`else
    hdr_hit  = 1'b0;
    pidx     = addr;
    hdr_byte = 8'h00;
`endif
    in_range = !hdr_hit && (pidx < NBYTES_A);
    accept   = (state == IDLE) && !wait_o && rd && upload;
  end

  pix_packer u_packer (
    .clk         (clk_sys),
    .reset       (reset),
    .clear       (accept && in_range),
    .load        (q_valid),
    .pix         (mem_q),
    .packed_next (packed_next)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      dout      <= 8'h00;
      wait_o    <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      k         <= 3'd0;
      issue     <= 1'b0;
      q_valid   <= 1'b0;
      last_byte <= 1'b0;
    end else if (!upload) begin
      state   <= IDLE;
      wait_o  <= 1'b0;
      mem_rd  <= 1'b0;
      done    <= 1'b0;
      issue   <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      // mem_q belongs to the address issued one cycle earlier.
      q_valid <= issue;
      case (state)
        IDLE: begin
          if (wait_o) begin
            wait_o <= 1'b0;
          end else if (accept) begin
            wait_o <= 1'b1;
            if (in_range) begin
              mem_addr  <= ADDR_W'({pidx, 2'b00});
              mem_rd    <= 1'b1;
              issue     <= 1'b1;
              k         <= 3'd1;
              last_byte <= (pidx == NBYTES_A - 25'd1);
              state     <= FETCH;
            end else begin
              dout <= hdr_hit ? hdr_byte : 8'h00;
            end
          end
        end
        FETCH: begin
          if (!k[2]) begin
            mem_addr[1:0] <= k[1:0];
            k             <= k + 3'd1;
            issue         <= 1'b1;
          end else begin
            issue <= 1'b0;
            state <= LAST;
          end
        end
        LAST: begin
          dout   <= packed_next;
          wait_o <= 1'b0;
          mem_rd <= 1'b0;
          if (last_byte) done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vbuffer_upload.sv
// Randomized bench for vbuffer_upload against a byte-level frame model.
module tb_vbuffer_upload;
  import sv_video_pkg::*;

  localparam int ADDR_W = 15;
  localparam int NPIX   = SV_WIDTH_PX * SV_HEIGHT_PX;
  localparam int NBYTES = NPIX / 4;
`ifdef VBUF_UPLOAD_HEADER_EN
  localparam int OFS = 4;
`else
  localparam int OFS = 0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              upload  = 1'b0;
  logic              rd      = 1'b0;
  logic [24:0]       addr    = '0;
  logic [7:0]        dout;
  logic              wait_o;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [1:0]        mem_q = 2'b00;

  logic [1:0] fb [0:NPIX-1];
  logic [7:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;
  logic       exp_done  = 1'b0;
  int         n_checks  = 0;
  int         n_pass    = 0;

  vbuffer_upload dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .upload   (upload),
    .rd       (rd),
    .addr     (addr),
    .dout     (dout),
    .wait_o   (wait_o),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_q    (mem_q)
  );

  // clock / frame buffer model with one-cycle read latency
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    mem_q <= (int'(mem_addr) < NPIX) ? fb[mem_addr] : 2'b00;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit in_payload(input int a);
    return (a >= OFS) && (a < OFS + NBYTES);
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    int p;
    int b;
    if (OFS != 0 && a < OFS) begin
      case (a)
        0:       return 8'h53;
        1:       return 8'h56;
        2:       return 8'(SV_WIDTH_PX);
        default: return 8'(SV_HEIGHT_PX);
      endcase
    end
    if (!in_payload(a)) return 8'h00;
    p = a - OFS;
    b = 0;
    for (int i = 0; i < 4; i++) b = b * 4 + int'(fb[p * 4 + i]);
    return 8'(b);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       fb[i] = 2'(i);
        1:       fb[i] = 2'b11;
        default: fb[i] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  // Issues one read; extra_rd re-pulses rd during the first two busy cycles.
  task automatic do_read(input int a, input bit extra_rd);
    int waits;
    int nrd;
    logic [31:0] seen[$];
    exp_q.push_back(model_byte(a));
    @(negedge clk_sys);
    rd = 1'b1;
    addr = 25'(a);
    @(negedge clk_sys);
    rd = 1'b0;
    waits = 0;
    nrd = 0;
    while (wait_o === 1'b1 && waits < 20) begin
      if (mem_rd === 1'b1) begin
        nrd++;
        if (seen.size() < 4) seen.push_back(32'(mem_addr));
      end
      if (extra_rd && waits < 2) begin
        rd = 1'b1;
        addr = 25'($urandom_range(0, NBYTES - 1));
      end else begin
        rd = 1'b0;
      end
      @(negedge clk_sys);
      waits++;
    end
    rd = 1'b0;
    check_eq("wait_len", 32'(waits), in_payload(a) ? 32'd5 : 32'd1);
    last_dout = exp_q.pop_front();
    check_eq("dout", 32'(dout), 32'(last_dout));
    if (in_payload(a)) begin
      for (int i = 0; i < 4; i++)
        check_eq("mem_addr_seq", (seen.size() > i) ? seen[i] : 32'hFFFF_FFFF,
                 32'(((a - OFS) * 4 + i) % (1 << ADDR_W)));
    end else begin
      check_eq("no_mem_rd", 32'(nrd), 32'd0);
    end
    if (a == OFS + NBYTES - 1) exp_done = 1'b1;
    check_eq("done", 32'(done), 32'(exp_done));
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_dout);
    check_eq({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    check_eq({tag, "_wait"}, 32'(wait_o), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check_eq({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    int a;
    int hi;
    fill(0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check_idle_outputs("reset", 8'h00);
    check_eq("reset_mem_addr", 32'(mem_addr), 32'd0);

    // rd without an upload session does nothing
    @(negedge clk_sys);
    rd = 1'b1;
    addr = 25'(OFS);
    @(negedge clk_sys);
    rd = 1'b0;
    check_eq("no_upload_wait", 32'(wait_o), 32'd0);
    check_eq("no_upload_mem_rd", 32'(mem_rd), 32'd0);

    upload = 1'b1;
`ifdef VBUF_UPLOAD_HEADER_EN
    for (int h = 0; h < 4; h++) do_read(h, 1'b0);
`endif
    do_read(OFS, 1'b0);
    check_eq("pattern_byte0", 32'(dout), 32'h1B);

    fill(1);
    do_read(OFS + NBYTES - 1, 1'b0);
    do_read(OFS + NBYTES, 1'b0);
    do_read(OFS + NBYTES + 37, 1'b0);

    @(negedge clk_sys);
    upload = 1'b0;
    exp_done = 1'b0;
    @(negedge clk_sys);
    check_eq("done_clear_on_upload_low", 32'(done), 32'd0);
    upload = 1'b1;

    fill(2);
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, OFS + NBYTES + 50))
                                       : int'($urandom_range(OFS, OFS + NBYTES - 1));
      do_read(a, 1'b0);
    end
    do_read(OFS + NBYTES - 1, 1'b0);

    // rd pulses while busy must not queue another fetch
    do_read(OFS + int'($urandom_range(0, NBYTES - 1)), 1'b1);
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      if (wait_o !== 1'b0 || mem_rd !== 1'b0) hi++;
    end
    check_eq("no_queued_read", 32'(hi), 32'd0);

    // upload drop mid-fetch aborts, dout keeps the previous byte
    @(negedge clk_sys);
    rd = 1'b1;
    addr = 25'(OFS + 100);
    @(negedge clk_sys);
    rd = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    upload = 1'b0;
    @(negedge clk_sys);
    check_idle_outputs("abort", last_dout);
    exp_done = 1'b0;
    upload = 1'b1;
    do_read(OFS, 1'b0);

    // reset mid-fetch
    @(negedge clk_sys);
    rd = 1'b1;
    addr = 25'(OFS + 200);
    @(negedge clk_sys);
    rd = 1'b0;
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check_idle_outputs("midreset", 8'h00);
    check_eq("midreset_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    exp_done = 1'b0;
    do_read(OFS + 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
